axis_pulse_detect: RTL and testbench
====================================

AXIS_PULSE_DETECT -- requirements
Module: axis_pulse_detect

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed ADC sample width.
REQ-002 SHALL have parameter THRESH_HI, default 16000, meaning signed rising threshold (sample >= THRESH_HI).
REQ-003 SHALL have parameter THRESH_LO, default 8000, meaning signed falling threshold (sample < THRESH_LO); THRESH_LO <= THRESH_HI.
REQ-004 SHALL have parameter MIN_WIDTH, default 4, meaning minimum qualified pulse width in samples.
REQ-005 SHALL have parameter MAX_WIDTH, default 1024, meaning timeout width (used only with the timeout feature).
REQ-006 SHALL have parameter TS_WIDTH, default 32, meaning timestamp/period width.
REQ-007 aclk  in  1  clock; all logic on its rising edge.
REQ-008 aresetn  in  1  reset, asynchronous, active-low.
REQ-009 s_axis_tdata  in  DATA_WIDTH  signed sample from RFDC ADC.
REQ-010 s_axis_tvalid  in  1  sample valid.
REQ-011 s_axis_tready  out  1  sample accept.
REQ-012 res_valid  out  1  result available.
REQ-013 res_ready  in  1  result consumed.
REQ-014 res_width  out  16  pulse width in accepted samples.
REQ-015 res_peak  out  DATA_WIDTH  maximum signed sample within pulse.
REQ-016 res_ts  out  TS_WIDTH  timestamp of pulse rising sample.
REQ-017 res_period  out  TS_WIDTH  samples between this and previous reported rising sample.
REQ-018 res_timeout  out  1  pulse terminated by timeout.
REQ-019 drop_cnt  out  16  results lost to a full holding register.

Function
REQ-020 s_axis_tready SHALL be registered 1 whenever out of reset; the block SHALL never back-pressure.
REQ-021 A sample SHALL count as accepted only when s_axis_tvalid && s_axis_tready.
REQ-022 Timestamp counter ts SHALL increment by 1 per accepted sample, wrapping modulo 2^TS_WIDTH.
REQ-023 FSM states SHALL be IDLE, ACTIVE, WAIT_LOW (WAIT_LOW exists only with the timeout feature).
REQ-024 IDLE: accepted sample >= THRESH_HI -> ACTIVE; latch rise_ts = ts, width = 1, peak = sample.
REQ-025 ACTIVE: accepted sample >= THRESH_LO -> width += 1 (saturate at 0xFFFF), peak = max(peak, sample).
REQ-026 ACTIVE: accepted sample < THRESH_LO -> IDLE; falling sample excluded from width/peak.
REQ-027 On ACTIVE->IDLE with width >= MIN_WIDTH, result SHALL be issued; with width < MIN_WIDTH, pulse discarded silently, last_ts unchanged.
REQ-028 Issued result: res_ts = rise_ts, res_period = rise_ts - last_ts (modulo), or 0 for first pulse after reset; then last_ts = rise_ts.
REQ-029 res_valid SHALL assert the cycle after the terminating sample is accepted (latency 1).
REQ-030 res_* SHALL hold stable while res_valid && !res_ready.
REQ-031 New result while res_valid && !res_ready SHALL be dropped, holding unchanged, drop_cnt += 1 saturating at 0xFFFF.
REQ-032 New result in the same cycle as res_valid && res_ready SHALL load, no drop; res_valid stays 1.
REQ-033 Cycles without an accepted sample SHALL leave FSM, counters and ts unchanged.

Reset
REQ-034 Reset SHALL force: s_axis_tready=0, res_valid=0, res_width/peak/ts/period=0, res_timeout=0, drop_cnt=0, ts=0, FSM=IDLE, first-pulse flag set.
REQ-035 Reset during ACTIVE SHALL discard the pulse with no result.

Configuration
REQ-036 Macro PULSE_DET_TIMEOUT_EN defined: in ACTIVE, when width reaches MAX_WIDTH, result issued with res_timeout=1, FSM -> WAIT_LOW; WAIT_LOW -> IDLE on accepted sample < THRESH_LO, no further result.
REQ-037 Macro undefined: no WAIT_LOW, res_timeout tied 0, width saturates per REQ-025.

Structure
REQ-038 Package pulse_det_pkg SHALL hold FSM state enum, result width constant (16) and drop counter width.
REQ-039 Sub-module pulse_det_result_reg SHALL implement holding register, res_valid/res_ready handshake and drop_cnt.

Verification
REQ-040 Stream 0 x10, 20000 x8, 0 x10 -> one result, width=8, peak=20000, period=0, res_timeout=0.
REQ-041 Two 8-sample pulses of 20000, rising samples 100 apart -> second result period=100.
REQ-042 Glitch 20000 x3 then 0 -> no result, last_ts unchanged; next pulse period measured from prior qualified pulse.
REQ-043 res_ready=0, three qualified pulses -> first held stable, drop_cnt=2; res_ready=1 -> res_valid falls next cycle.
REQ-044 PULSE_DET_TIMEOUT_EN, 20000 x2000 -> result width=1024, res_timeout=1, single result until sample < 8000.
REQ-045 aresetn low mid-pulse, then 20000 x8 -> no stale result, new result period=0, res_ts counted from reset.

Source files
------------

// File: rtl/pulse_det_pkg.sv
// Shared types and constants for the AXI-Stream pulse detector.
package pulse_det_pkg;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  localparam int RES_W  = 16;
  localparam int DROP_W = 16;
endpackage

// File: rtl/pulse_det_result_reg.sv
// Single-entry result holding register with valid/ready handshake and a
// saturating counter of results lost while the entry was still occupied.
module pulse_det_result_reg
  import pulse_det_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TS_WIDTH   = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         i_load,
  input  logic [RES_W-1:0]             i_width,
  input  logic signed [DATA_WIDTH-1:0] i_peak,
  input  logic [TS_WIDTH-1:0]          i_ts,
  input  logic [TS_WIDTH-1:0]          i_period,
  input  logic                         i_timeout,
  input  logic                         i_ready,
  output logic                         o_valid,
  output logic [RES_W-1:0]             o_width,
  output logic signed [DATA_WIDTH-1:0] o_peak,
  output logic [TS_WIDTH-1:0]          o_ts,
  output logic [TS_WIDTH-1:0]          o_period,
  output logic                         o_timeout,
  output logic [DROP_W-1:0]            o_drop_cnt
);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                         r_valid;
  logic [RES_W-1:0]             r_width;
  logic signed [DATA_WIDTH-1:0] r_peak;
  logic [TS_WIDTH-1:0]          r_ts;
  logic [TS_WIDTH-1:0]          r_period;
  logic                         r_timeout;
  logic [DROP_W-1:0]            r_drop_cnt;
  logic                         w_busy;

  // A consumer taking the old entry this cycle frees the slot for the new one.
  assign w_busy = r_valid && !i_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid    <= 1'b0;
      r_width    <= '0;
      r_peak     <= '0;
      r_ts       <= '0;
      r_period   <= '0;
      r_timeout  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_load && !w_busy) begin
      r_valid   <= 1'b1;
      r_width   <= i_width;
      r_peak    <= i_peak;
      r_ts      <= i_ts;
      r_period  <= i_period;
      r_timeout <= i_timeout;
    end else if (i_load) begin
      r_drop_cnt <= sat_inc(r_drop_cnt);
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_width    = r_width;
  assign o_peak     = r_peak;
  assign o_ts       = r_ts;
  assign o_period   = r_period;
  assign o_timeout  = r_timeout;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/axis_pulse_detect.sv
// Hysteresis pulse detector on a signed ADC stream: reports width, peak,
// rise timestamp and period. Define PULSE_DET_TIMEOUT_EN for MAX_WIDTH timeout.
module axis_pulse_detect
  import pulse_det_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int THRESH_HI  = 16000,
  parameter int THRESH_LO  = 8000,
  parameter int MIN_WIDTH  = 4,
  parameter int MAX_WIDTH  = 1024,
  parameter int TS_WIDTH   = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic signed [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [RES_W-1:0]             res_width,
  output logic signed [DATA_WIDTH-1:0] res_peak,
  output logic [TS_WIDTH-1:0]          res_ts,
  output logic [TS_WIDTH-1:0]          res_period,
  output logic                         res_timeout,
  output logic [DROP_W-1:0]            drop_cnt
);

  localparam logic signed [DATA_WIDTH-1:0] C_HI  = DATA_WIDTH'(THRESH_HI);
  localparam logic signed [DATA_WIDTH-1:0] C_LO  = DATA_WIDTH'(THRESH_LO);
  localparam logic [RES_W-1:0]             C_MIN = RES_W'(MIN_WIDTH);
`ifdef PULSE_DET_TIMEOUT_EN
  localparam logic [RES_W-1:0]             C_MAX = RES_W'(MAX_WIDTH);
`endif

  function automatic logic [RES_W-1:0] sat_inc(input logic [RES_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                         r_tready;
  logic [TS_WIDTH-1:0]          r_ts;
  state_t                       r_state;
  logic                         r_first;
  logic [RES_W-1:0]             r_width;
  logic signed [DATA_WIDTH-1:0] r_peak;
  logic [TS_WIDTH-1:0]          r_rise_ts;
  logic [TS_WIDTH-1:0]          r_last_ts;

  logic                         w_acc;
  logic                         w_ge_hi;
  logic                         w_ge_lo;
  logic [RES_W-1:0]             w_width_inc;
  logic signed [DATA_WIDTH-1:0] w_peak_max;
  state_t                       w_nstate;
  logic                         w_issue;
  logic [RES_W-1:0]             w_res_width;
  logic signed [DATA_WIDTH-1:0] w_res_peak;
  logic                         w_res_to;
  logic [TS_WIDTH-1:0]          w_period;

  assign w_acc       = s_axis_tvalid && r_tready;
  assign w_ge_hi     = s_axis_tdata >= C_HI;
  assign w_ge_lo     = s_axis_tdata >= C_LO;
  assign w_width_inc = sat_inc(r_width);
  assign w_peak_max  = (s_axis_tdata > r_peak) ? s_axis_tdata : r_peak;
  assign w_period    = r_first ? '0 : r_rise_ts - r_last_ts;

  always_comb begin
    w_nstate    = r_state;
    w_issue     = 1'b0;
    w_res_width = r_width;
    w_res_peak  = r_peak;
    w_res_to    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_acc && w_ge_hi) w_nstate = ST_IDLE == ST_IDLE ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE: begin
        // The falling sample itself is not part of the pulse.
        if (w_acc && !w_ge_lo) begin
          w_nstate = ST_IDLE;
          w_issue  = (r_width >= C_MIN);
        end
`ifdef PULSE_DET_TIMEOUT_EN
        else if (w_acc && (w_width_inc == C_MAX)) begin
          w_nstate    = ST_WAIT_LOW;
          w_issue     = 1'b1;
          w_res_width = w_width_inc;
          w_res_peak  = w_peak_max;
          w_res_to    = 1'b1;
        end
`endif
      end
`ifdef PULSE_DET_TIMEOUT_EN
      ST_WAIT_LOW: if (w_acc && !w_ge_lo) w_nstate = ST_IDLE;
`endif
      default: w_nstate = ST_IDLE;
    endcase
  end

  // Control: handshake, timestamp, FSM, first-pulse flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tready <= 1'b0;
      r_ts     <= '0;
      r_state  <= ST_IDLE;
      r_first  <= 1'b1;
    end else begin
      r_tready <= 1'b1;
      r_state  <= w_nstate;
      if (w_acc) r_ts <= r_ts + 1'b1;
      if (w_issue) r_first <= 1'b0;
    end
  end

  // Datapath: pulse accumulation, no reset needed (loaded on every rise)
  always_ff @(posedge aclk) begin
    if (w_acc && (r_state == ST_IDLE) && w_ge_hi) begin
      r_rise_ts <= r_ts;
      r_width   <= RES_W'(1);
      r_peak    <= s_axis_tdata;
    end else if (w_acc && (r_state == ST_ACTIVE) && w_ge_lo) begin
      r_width <= w_width_inc;
      r_peak  <= w_peak_max;
    end
    if (w_issue) r_last_ts <= r_rise_ts;
  end

  assign s_axis_tready = r_tready;

  pulse_det_result_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .TS_WIDTH   (TS_WIDTH)
  ) u_result (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .i_load     (w_issue),
    .i_width    (w_res_width),
    .i_peak     (w_res_peak),
    .i_ts       (r_rise_ts),
    .i_period   (w_period),
    .i_timeout  (w_res_to),
    .i_ready    (res_ready),
    .o_valid    (res_valid),
    .o_width    (res_width),
    .o_peak     (res_peak),
    .o_ts       (res_ts),
    .o_period   (res_period),
    .o_timeout  (res_timeout),
    .o_drop_cnt (drop_cnt)
  );

endmodule

// File: tb/tb_axis_pulse_detect.sv
// Directed bench for axis_pulse_detect; long-pulse expectations follow
// PULSE_DET_TIMEOUT_EN when it is defined.
module tb_axis_pulse_detect;
  logic               aclk = 1'b0;
  logic               aresetn;
  logic signed [15:0] s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic               res_valid;
  logic               res_ready;
  logic [15:0]        res_width;
  logic signed [15:0] res_peak;
  logic [31:0]        res_ts;
  logic [31:0]        res_period;
  logic               res_timeout;
  logic [15:0]        drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

`ifdef PULSE_DET_TIMEOUT_EN
  localparam int NLONG = 2000;
  localparam int WLONG = 1024;
  localparam bit TLONG = 1'b1;
`else
  localparam int NLONG = 1100;
  localparam int WLONG = 1100;
  localparam bit TLONG = 1'b0;
`endif

  typedef struct {
    int     w;
    int     pk;
    longint ts;
    longint per;
    bit     to;
  } res_t;
  res_t cap[$];

  axis_pulse_detect dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_width     (res_width),
    .res_peak      (res_peak),
    .res_ts        (res_ts),
    .res_period    (res_period),
    .res_timeout   (res_timeout),
    .drop_cnt      (drop_cnt)
  );

  always #5 aclk = ~aclk;

  // Every completed handshake is one delivered result.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1)
      cap.push_back('{int'(res_width), int'(res_peak), longint'(res_ts),
                      longint'(res_period), res_timeout});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic signed [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = v;
      s_axis_tvalid = 1'b1;
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic chk_cap(input int idx, input int w, input int pk, input longint ts,
                         input longint per, input bit chk_per, input bit to);
    if (idx >= cap.size()) begin
      chk($sformatf("cap%0d_present", idx), 64'(cap.size()), 64'(idx + 1));
    end else begin
      chk($sformatf("cap%0d_width", idx), 64'(cap[idx].w), 64'(w));
      chk($sformatf("cap%0d_peak", idx), 64'(cap[idx].pk), 64'(pk));
      chk($sformatf("cap%0d_ts", idx), 64'(cap[idx].ts), 64'(ts));
      if (chk_per) chk($sformatf("cap%0d_period", idx), 64'(cap[idx].per), 64'(per));
      chk($sformatf("cap%0d_timeout", idx), 64'(cap[idx].to), 64'(to));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
    chk({tag, "_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_width"}, 64'(res_width), 64'd0);
    chk({tag, "_peak"}, 64'(res_peak), 64'd0);
    chk({tag, "_ts"}, 64'(res_ts), 64'd0);
    chk({tag, "_period"}, 64'(res_period), 64'd0);
    chk({tag, "_timeout"}, 64'(res_timeout), 64'd0);
    chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    res_ready     = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk_reset_state("rst0");
    aresetn = 1'b1;
    idle(1);
    chk("tready_up", 64'(s_axis_tready), 64'd1);

    // Basic pulse with an idle gap inside it: ts 10..17, falls at ts 18
    smp(0, 10);
    smp(20000, 4);
    idle(3);
    smp(20000, 4);
    chk("lat_before_fall", 64'(res_valid), 64'd0);
    smp(0, 1);
    chk("lat_after_fall", 64'(res_valid), 64'd1);
    smp(0, 9);
    chk("cnt_after_a", 64'(cap.size()), 64'd1);
    chk_cap(0, 8, 20000, 10, 0, 1'b1, 1'b0);

    // Two pulses with rising samples at ts 28 and 128
    smp(20000, 8);
    smp(0, 92);
    smp(17000, 1); smp(25000, 1); smp(30000, 1);
    smp(9000, 1);  smp(12000, 1); smp(20000, 1);
    smp(0, 10);
    chk_cap(1, 8, 20000, 28, 18, 1'b1, 1'b0);
    chk_cap(2, 6, 30000, 128, 100, 1'b1, 1'b0);

    // Below-threshold start, glitch, then exact-threshold pulse at ts 160
    smp(15999, 3);
    smp(20000, 3);
    smp(0, 10);
    chk("cnt_after_glitch", 64'(cap.size()), 64'd3);
    smp(16000, 1);
    smp(8000, 3);
    smp(7999, 1);
    smp(0, 5);
    chk_cap(3, 4, 16000, 160, 32, 1'b1, 1'b0);
    smp(-20000, 6);
    chk("cnt_after_neg", 64'(cap.size()), 64'd4);

    // Three results with the consumer stalled: first is held, two dropped
    res_ready = 1'b0;
    smp(20000, 5); smp(0, 5);
    smp(21000, 5); smp(0, 5);
    smp(22000, 5); smp(0, 5);
    chk("hold_valid", 64'(res_valid), 64'd1);
    chk("hold_width", 64'(res_width), 64'd5);
    chk("hold_peak", 64'(res_peak), 64'd20000);
    chk("hold_ts", 64'(res_ts), 64'd176);
    chk("hold_period", 64'(res_period), 64'd16);
    chk("drop_two", 64'(drop_cnt), 64'd2);
    res_ready = 1'b1;
    smp(0, 1);
    chk("release_valid", 64'(res_valid), 64'd0);
    chk_cap(4, 5, 20000, 176, 16, 1'b1, 1'b0);

    // Load in the same cycle the held entry is consumed
    res_ready = 1'b0;
    smp(23000, 6);
    smp(0, 4);
    smp(24000, 7);
    res_ready = 1'b1;
    smp(0, 1);
    chk("swap_valid", 64'(res_valid), 64'd1);
    chk("swap_width", 64'(res_width), 64'd7);
    chk("swap_peak", 64'(res_peak), 64'd24000);
    chk("swap_ts", 64'(res_ts), 64'd217);
    chk("swap_drop", 64'(drop_cnt), 64'd2);
    smp(0, 1);
    chk("swap_drain", 64'(res_valid), 64'd0);
    chk_cap(5, 6, 23000, 207, 0, 1'b0, 1'b0);
    chk_cap(6, 7, 24000, 217, 0, 1'b0, 1'b0);

    // Reset in the middle of a qualifying pulse
    smp(20000, 6);
    s_axis_tdata  = 20000;
    s_axis_tvalid = 1'b1;
    aresetn       = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk_reset_state("rst1");
    aresetn = 1'b1;
    idle(1);
    chk("cnt_after_rst", 64'(cap.size()), 64'd7);
    smp(20000, 8);
    smp(0, 4);
    chk_cap(7, 8, 20000, 0, 0, 1'b1, 1'b0);

    // Long pulse starting at ts 12
    smp(20000, NLONG);
    smp(0, 5);
    chk_cap(8, WLONG, 20000, 12, 12, 1'b1, TLONG);
    chk("cnt_final", 64'(cap.size()), 64'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
